fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder buffer placed directly downstream of the last FFT butterfly stage. It accepts complex results in bit-reversed index order, one sample per clock when valid. It emits each frame in natural index order from a ping-pong pair of frame banks, with frame-start and error flags, so consumers see a continuous naturally ordered stream.

## Interface
- DBW, 4: bits per real/imag component; a sample is 2*DBW bits, imag in [2*DBW-1:DBW], real in [DBW-1:0]
- CBW, 3: log2 of frame length; N = 1<<CBW samples per frame
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- din_vld  input  1  din holds a valid sample this cycle
- din_sof  input  1  with din_vld: this sample is index 0 of a new frame (bit-reversed sequence position 0)
- din  input  2*DBW  sample in bit-reversed order
- dout_vld  output  1  dout valid
- dout_sof  output  1  with dout_vld: natural index 0 of a frame
- dout  output  2*DBW  sample in natural order
- frame_err  output  1  one-cycle pulse: framing violation, details under Operation
- ovf  output  1  one-cycle pulse: frame dropped because target bank still full

## Operation
- Storage: two banks of N x 2*DBW words (bank0, bank1) and one full flag per bank. Memory contents are not reset.
- Writer states: W_IDLE (waiting for sof) and W_FILL. It has a write counter wcnt[CBW-1:0] and a bank pointer wbank.
  - W_IDLE, din_vld & din_sof: if full[wbank]=0, write din to address bitrev(0)=0, set wcnt=1, go to W_FILL. Otherwise pulse ovf and stay in W_IDLE; the frame is dropped.
  - W_IDLE, din_vld & !din_sof: sample dropped, pulse frame_err.
  - W_FILL, din_vld & !din_sof: write to address bitrev(wcnt), then wcnt+1.
    - On the write with wcnt=N-1: set full[wbank], toggle wbank, clear wcnt, go to W_IDLE.
  - W_FILL, din_vld & din_sof: abort the partial frame (bank not marked full), pulse frame_err, and restart at index 0 in the same bank with this sample; wcnt=1.
  - din_vld=0 in any state: no change. Gaps inside a frame are allowed.
- bitrev(x): bit i of the address is bit CBW-1-i of x.
- Reader states: R_IDLE and R_READ. It has a read counter rcnt[CBW-1:0] and a bank pointer rbank.
  - R_IDLE with full[rbank]=1: go to R_READ.
  - R_READ: each cycle register dout <= bank[rbank][rcnt], dout_vld=1, dout_sof=(rcnt==0); then rcnt+1.
  - On rcnt=N-1: clear full[rbank] and toggle rbank. If full of the new rbank is 1, continue in R_READ with no gap; otherwise go to R_IDLE.
  - There is no output backpressure. The reader runs N consecutive cycles per frame.
- Simultaneous events:
  - A full-set by the writer and a full-clear by the reader act on different banks, so both take effect.
  - A writer starting a new frame on the same edge that the reader clears that bank's full sees full=0 combinationally from the reader's clear and is accepted.
- Outputs when dout_vld=0: dout holds its last value; dout_sof=0.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - W_IDLE, R_IDLE, wcnt=rcnt=0, wbank=rbank=0, full=00
  - dout_vld=0, dout_sof=0, dout=0, frame_err=0, ovf=0
- Reset mid-frame discards all buffered and partial frames.
- Write-to-read latency: last sample of a frame presented in cycle k gives dout_vld=1 and dout_sof=1 in cycle k+2. The frame then occupies cycles k+2..k+N+1.
- Continuous input (din_vld=1 every cycle, sof every N cycles) gives continuous output with no bubbles and never asserts ovf.
- frame_err and ovf are registered and asserted in the cycle after the offending input cycle.

## Test plan
- Single frame, DBW=4, CBW=3: din_vld=1 for 8 cycles, din = natural index in bitrev order (0,4,2,6,1,5,3,7 in the real field), sof on first -> 2 cycles after last input, dout real = 0..7 on consecutive cycles, dout_sof only with 0, frame_err=ovf=0.
- Back-to-back: 4 continuous frames with distinct imag tags 1..4 -> 32 contiguous output cycles in natural order, tags in sequence, dout_sof every 8th cycle, no bubble.
- Gapped input: din_vld toggling 1,0,1,0 within a frame -> output still a contiguous 8-cycle burst starting 2 cycles after the last valid sample, values correct.
- Framing errors:
  - 3 samples without sof after reset -> frame_err pulses 3 times, no output.
  - Sof at wcnt=5 mid-frame -> frame_err once, partial frame never output, the new frame is output correctly.
- Overflow: force both banks full with the reader idle via reset release timing, or drive a bench-forced state, then sof -> ovf pulse, dropped frame not output.
- Reset mid-read: assert rst_n=0 during output cycle 3 of a frame -> dout_vld=0 immediately (asynchronous). After release with no new input, no output. The next full frame is output normally with 2-cycle latency.

Source files
------------

// File: rtl/fft_reorder.sv
`default_nettype none
// fft_reorder -- ping-pong buffer turning bit-reversed FFT output into a natural-order stream.
// Revision 1.0 -- initial release.
module fft_reorder #(
  parameter int DBW = 4,
  parameter int CBW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic             din_sof,
  input  logic [2*DBW-1:0] din,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic [2*DBW-1:0] dout,
  output logic             frame_err,
  output logic             ovf
);

  localparam int             N      = 1 << CBW;
  localparam logic [CBW-1:0] C_LAST = CBW'(N - 1);
  localparam logic [CBW-1:0] C_ONE  = CBW'(1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_READ = 1'b1} rd_state_t;

  logic [2*DBW-1:0] mem [2][N];

  wr_state_t      r_wstate, w_wstate_nx;
  rd_state_t      r_rstate, w_rstate_nx;
  logic [CBW-1:0] r_wcnt, w_wcnt_nx;
  logic [CBW-1:0] r_rcnt, w_rcnt_nx;
  logic           r_wbank, w_wbank_nx;
  logic           r_rbank, w_rbank_nx;
  logic [1:0]     r_full, w_full_nx;

  logic           w_wr_en;
  logic [CBW-1:0] w_wr_addr;
  logic           w_set_full;
  logic           w_err_nx;
  logic           w_ovf_nx;
  logic           w_rd_en;
  logic           w_rd_last;
  logic           w_full_eff;

  function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] x);
    logic [CBW-1:0] r;
    for (int i = 0; i < CBW; i++) r[i] = x[CBW-1-i];
    return r;
  endfunction

  // A full bank is drained every cycle it is full, so the read can start from R_IDLE.
  always_comb begin
    w_rd_en   = (r_rstate == R_READ) || r_full[r_rbank];
    w_rd_last = w_rd_en && (r_rcnt == C_LAST);
  end

  // The reader's clear on this edge frees the bank for a writer sof on the same edge.
  always_comb begin
    w_full_eff = r_full[r_wbank] && !(w_rd_last && (r_rbank == r_wbank));
  end

  always_comb begin
    w_wstate_nx = r_wstate;
    w_wcnt_nx   = r_wcnt;
    w_wbank_nx  = r_wbank;
    w_wr_en     = 1'b0;
    w_wr_addr   = bitrev(r_wcnt);
    w_set_full  = 1'b0;
    w_err_nx    = 1'b0;
    w_ovf_nx    = 1'b0;
    if (din_vld) begin
      case (r_wstate)
        W_IDLE: begin
          if (!din_sof) begin
            w_err_nx = 1'b1;
          end else if (w_full_eff) begin
            w_ovf_nx = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_wr_addr   = '0;
            w_wcnt_nx   = C_ONE;
            w_wstate_nx = W_FILL;
          end
        end
        W_FILL: begin
          w_wr_en = 1'b1;
          if (din_sof) begin
            // Restart the frame in place; the partial bank is never marked full.
            w_err_nx  = 1'b1;
            w_wr_addr = '0;
            w_wcnt_nx = C_ONE;
          end else if (r_wcnt == C_LAST) begin
            w_set_full  = 1'b1;
            w_wbank_nx  = ~r_wbank;
            w_wcnt_nx   = '0;
            w_wstate_nx = W_IDLE;
          end else begin
            w_wcnt_nx = r_wcnt + 1'b1;
          end
        end
        default: begin
          w_wstate_nx = W_IDLE;
        end
      endcase
    end
  end

  // Set and clear always target different banks: only an empty bank is filled.
  always_comb begin
    w_full_nx = r_full;
    if (w_set_full) w_full_nx[r_wbank] = 1'b1;
    if (w_rd_last)  w_full_nx[r_rbank] = 1'b0;

    w_rstate_nx = r_rstate;
    w_rcnt_nx   = r_rcnt;
    w_rbank_nx  = r_rbank;
    if (w_rd_en) begin
      w_rstate_nx = R_READ;
      w_rcnt_nx   = r_rcnt + 1'b1;
      if (w_rd_last) begin
        w_rbank_nx  = ~r_rbank;
        w_rstate_nx = w_full_nx[~r_rbank] ? R_READ : R_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) mem[r_wbank][w_wr_addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_full    <= 2'b00;
      dout_vld  <= 1'b0;
      dout_sof  <= 1'b0;
      dout      <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nx;
      r_rstate  <= w_rstate_nx;
      r_wcnt    <= w_wcnt_nx;
      r_rcnt    <= w_rcnt_nx;
      r_wbank   <= w_wbank_nx;
      r_rbank   <= w_rbank_nx;
      r_full    <= w_full_nx;
      dout_vld  <= w_rd_en;
      dout_sof  <= w_rd_en && (r_rcnt == '0);
      if (w_rd_en) dout <= mem[r_rbank][r_rcnt];
      frame_err <= w_err_nx;
      ovf       <= w_ovf_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// tb_fft_reorder -- directed bench for fft_reorder with DBW=4, CBW=3.
// Revision 1.0 -- initial release.
module tb_fft_reorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_vld;
  logic       din_sof;
  logic [7:0] din;
  logic       dout_vld;
  logic       dout_sof;
  logic [7:0] dout;
  logic       frame_err;
  logic       ovf;

  fft_reorder #(.DBW(4), .CBW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_vld   (din_vld),
    .din_sof   (din_sof),
    .din       (din),
    .dout_vld  (dout_vld),
    .dout_sof  (dout_sof),
    .dout      (dout),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    int         c;
  } out_t;

  out_t outq[$];
  int   errq[$];
  int   ovf_cnt   = 0;
  int   sof_stray = 0;
  int   n_pass    = 0;
  int   n_total   = 0;

  // Outputs are sampled 1 time unit after the rising edge, tagged with the cycle number.
  always @(posedge clk) begin
    #1;
    if (dout_vld === 1'b1) outq.push_back('{dout, dout_sof, cyc});
    else if (dout_sof !== 1'b0) sof_stray++;
    if (frame_err === 1'b1) errq.push_back(cyc);
    if (ovf === 1'b1) ovf_cnt++;
  end

  function automatic logic [2:0] br3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, output int c);
    @(negedge clk);
    din_vld = v;
    din_sof = s;
    din     = d;
    c       = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    repeat (n) drive(1'b0, 1'b0, 8'h00, c);
  endtask

  // Imag field carries the frame tag, real field carries the natural index.
  task automatic send_frame(input logic [3:0] tag, input bit gap, output int klast);
    int c;
    int g;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, {tag, 1'b0, br3(3'(i))}, c);
      klast = c;
      if (gap && i < 7) drive(1'b0, 1'b0, 8'h00, g);
    end
  endtask

  task automatic check_frame(input string name, input int base, input logic [3:0] tag, input int c0);
    if (outq.size() < base + 8) begin
      chk({name, "_len"}, outq.size(), base + 8);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      chk({name, "_data"}, outq[base+i].d, {tag, 1'b0, 3'(i)});
      chk({name, "_sof"}, outq[base+i].sof, i == 0);
      chk({name, "_cyc"}, outq[base+i].c, c0 + i);
    end
  endtask

  task automatic clear_logs();
    outq.delete();
    errq.delete();
    ovf_cnt   = 0;
    sof_stray = 0;
  endtask

  initial begin
    int c, c0, k, k1;
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sof = 1'b0;
    din     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_vld", dout_vld, 0);
    chk("rst_sof", dout_sof, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    idle(2);

    // Samples without sof after reset are dropped with an error each.
    clear_logs();
    drive(1'b1, 1'b0, 8'h11, c0);
    drive(1'b1, 1'b0, 8'h12, c);
    drive(1'b1, 1'b0, 8'h13, c);
    idle(6);
    chk("noso_err_cnt", errq.size(), 3);
    chk("noso_err_cyc", errq.size() > 0 ? errq[0] : -1, c0 + 1);
    chk("noso_no_out", outq.size(), 0);

    // Single frame.
    clear_logs();
    send_frame(4'h0, 1'b0, k);
    idle(12);
    chk("single_len", outq.size(), 8);
    check_frame("single", 0, 4'h0, k + 2);
    chk("single_err", errq.size(), 0);
    chk("single_ovf", ovf_cnt, 0);
    chk("single_sof_stray", sof_stray, 0);

    // Four back-to-back frames form one unbroken 32-cycle burst.
    clear_logs();
    send_frame(4'h1, 1'b0, k1);
    send_frame(4'h2, 1'b0, k);
    send_frame(4'h3, 1'b0, k);
    send_frame(4'h4, 1'b0, k);
    idle(14);
    chk("b2b_len", outq.size(), 32);
    for (int f = 0; f < 4; f++) check_frame("b2b", f * 8, 4'(f + 1), k1 + 2 + f * 8);
    chk("b2b_ovf", ovf_cnt, 0);
    chk("b2b_err", errq.size(), 0);

    // Gapped input still yields a contiguous burst.
    clear_logs();
    send_frame(4'h5, 1'b1, k);
    idle(12);
    chk("gap_len", outq.size(), 8);
    check_frame("gap", 0, 4'h5, k + 2);

    // sof at wcnt=5 aborts the partial frame.
    clear_logs();
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, {4'h9, 1'b0, br3(3'(i))}, c);
    send_frame(4'h6, 1'b0, k);
    idle(12);
    chk("resof_err_cnt", errq.size(), 1);
    chk("resof_len", outq.size(), 8);
    check_frame("resof", 0, 4'h6, k + 2);

    // Reset during the third output cycle.
    clear_logs();
    send_frame(4'h7, 1'b0, k);
    idle(4);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", dout_vld, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_partial_len", outq.size(), 3);
    chk("mrst_third", outq.size() > 2 ? outq[2].d : 8'hFF, 8'h72);
    @(negedge clk);
    rst_n = 1'b1;
    idle(16);
    chk("mrst_no_out", outq.size(), 3);
    clear_logs();
    send_frame(4'h8, 1'b0, k);
    idle(12);
    chk("post_rst_len", outq.size(), 8);
    check_frame("post_rst", 0, 4'h8, k + 2);

    // Both banks forced full: the sof is refused and the rest of the frame is dropped.
    clear_logs();
    force dut.r_full = 2'b11;
    drive(1'b1, 1'b1, 8'hA0, c);
    drive(1'b1, 1'b0, 8'hA1, c);
    chk("ovf_pulse", ovf, 1);
    chk("ovf_no_err", frame_err, 0);
    drive(1'b0, 1'b0, 8'h00, c);
    chk("ovf_drop_err", frame_err, 1);
    chk("ovf_one_cycle", ovf, 0);
    rst_n = 1'b0;
    release dut.r_full;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    idle(12);
    chk("ovf_no_out", outq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
